// File: rtl/fmc_pkg.sv
// Shared encodings for the frequency-multiplier delay controller:
// Sel command codes, controller FSM states and the last-move record.
package fmc_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_INC  = 2'b01;
    localparam logic [1:0] SEL_DEC  = 2'b10;
    localparam logic [1:0] SEL_ILL  = 2'b11;

    typedef enum logic {
        TRACK,
        LOCKED
    } fsm_state_t;

    typedef enum logic [1:0] {
        NONE,
        UP,
        DOWN
    } move_t;

endpackage

// File: rtl/fmc_sel_filter.sv
// 3-deep majority filter over slot commands; a move passes only when at
// least 2 of the last 3 slots carried it. Used when FMC_SEL_FILTER_EN is set.
module fmc_sel_filter
    import fmc_pkg::*;
(
    input  logic       clk_ext,
    input  logic       rst_n,
    input  logic       i_slot,
    input  logic [1:0] i_sel,
    output logic [1:0] o_sel
);

    logic [1:0] r_hist1;
    logic [1:0] r_hist2;
    logic [1:0] w_cur;
    logic [1:0] w_inc_cnt;
    logic [1:0] w_dec_cnt;

    // Illegal commands are remembered as holds so they never vote.
    assign w_cur = (i_sel == SEL_ILL) ? SEL_HOLD : i_sel;

    assign w_inc_cnt = 2'(w_cur == SEL_INC) + 2'(r_hist1 == SEL_INC) + 2'(r_hist2 == SEL_INC);
    assign w_dec_cnt = 2'(w_cur == SEL_DEC) + 2'(r_hist1 == SEL_DEC) + 2'(r_hist2 == SEL_DEC);

    always_comb begin
        o_sel = SEL_HOLD;
        if (w_inc_cnt >= 2'd2) begin
            o_sel = SEL_INC;
        end else if (w_dec_cnt >= 2'd2) begin
            o_sel = SEL_DEC;
        end
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_hist1 <= SEL_HOLD;
            r_hist2 <= SEL_HOLD;
        end else if (i_slot) begin
            r_hist2 <= r_hist1;
            r_hist1 <= w_cur;
        end
    end

endmodule

// File: rtl/fmc_delay_ctrl.sv
// Integrates Sel correction commands into a saturating delay code and runs
// the lock detector. Optional majority filter: define FMC_SEL_FILTER_EN.
module fmc_delay_ctrl
    import fmc_pkg::*;
#(
    parameter int CODE_W    = 6,
    parameter int CODE_INIT = 32,
    parameter int LOCK_CNT  = 4
) (
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic              DIV_M,
    input  logic [1:0]        Sel,
    output logic [CODE_W-1:0] code_out,
    output logic              lock,
    output logic              at_limit,
    output logic              sel_err,
    output logic              upd
);

    localparam logic [CODE_W-1:0] CODE_MAX = '1;

    logic              r_div_q;
    logic [CODE_W-1:0] r_code;
    logic              r_at_limit;
    logic              r_sel_err;
    logic              r_upd;
    fsm_state_t        r_state;
    move_t             r_last;
    logic [3:0]        r_qcnt;
    logic              r_same;

    logic              w_slot;
    logic [1:0]        w_cmd;
    logic              w_up;
    logic              w_dn;
    logic              w_clip;
    logic              w_applied;
    logic              w_same_dir;
    logic              w_qual;
    fsm_state_t        w_state_next;
    logic [3:0]        w_qcnt_next;
    logic              w_same_next;

    assign w_slot = DIV_M & ~r_div_q;

`ifdef FMC_SEL_FILTER_EN
    fmc_sel_filter u_sel_filter (
        .clk_ext (clk_ext),
        .rst_n   (rst_n),
        .i_slot  (w_slot),
        .i_sel   (Sel),
        .o_sel   (w_cmd)
    );
`else
    assign w_cmd = Sel;
`endif

    assign w_up       = w_slot && (w_cmd == SEL_INC);
    assign w_dn       = w_slot && (w_cmd == SEL_DEC);
    assign w_clip     = (w_up && (r_code == CODE_MAX)) || (w_dn && (r_code == '0));
    assign w_applied  = (w_up || w_dn) && !w_clip;
    assign w_same_dir = w_applied && ((w_up && r_last == UP) || (w_dn && r_last == DOWN));
    // A first move (no prior direction) counts as a reversal.
    assign w_qual     = !w_clip && !w_same_dir;

    always_comb begin
        w_state_next = r_state;
        w_qcnt_next  = r_qcnt;
        w_same_next  = r_same;
        if (w_slot) begin
            case (r_state)
                TRACK: begin
                    w_same_next = 1'b0;
                    if (!w_qual) begin
                        w_qcnt_next = '0;
                    end else if (r_qcnt == 4'(LOCK_CNT - 1)) begin
                        w_state_next = LOCKED;
                        w_qcnt_next  = '0;
                    end else begin
                        w_qcnt_next = r_qcnt + 4'd1;
                    end
                end
                LOCKED: begin
                    // r_same marks that the previous applied move already repeated.
                    if (w_clip || (w_same_dir && r_same)) begin
                        w_state_next = TRACK;
                        w_qcnt_next  = '0;
                        w_same_next  = 1'b0;
                    end else if (w_same_dir) begin
                        w_same_next = 1'b1;
                    end else if (w_applied) begin
                        w_same_next = 1'b0;
                    end
                end
                default: begin
                    w_state_next = TRACK;
                    w_qcnt_next  = '0;
                    w_same_next  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q    <= 1'b0;
            r_code     <= CODE_W'(CODE_INIT);
            r_at_limit <= 1'b0;
            r_sel_err  <= 1'b0;
            r_upd      <= 1'b0;
            r_state    <= TRACK;
            r_last     <= NONE;
            r_qcnt     <= '0;
            r_same     <= 1'b0;
        end else begin
            r_div_q <= DIV_M;
            r_upd   <= w_slot;
            r_state <= w_state_next;
            r_qcnt  <= w_qcnt_next;
            r_same  <= w_same_next;
            if (w_slot) begin
                r_at_limit <= w_clip;
            end
            if (w_slot && (Sel == SEL_ILL)) begin
                r_sel_err <= 1'b1;
            end
            if (w_applied) begin
                r_code <= w_up ? (r_code + 1'b1) : (r_code - 1'b1);
                r_last <= w_up ? UP : DOWN;
            end
        end
    end

    assign code_out = r_code;
    assign lock     = (r_state == LOCKED);
    assign at_limit = r_at_limit;
    assign sel_err  = r_sel_err;
    assign upd      = r_upd;

endmodule

// File: tb/tb_fmc_delay_ctrl.sv
// Directed bench for fmc_delay_ctrl; the filter scenario runs when
// FMC_SEL_FILTER_EN is defined, the raw-command scenario otherwise.
module tb_fmc_delay_ctrl;

    logic       clk_ext = 1'b0;
    logic       rst_n   = 1'b0;
    logic       DIV_M   = 1'b0;
    logic [1:0] Sel     = 2'b00;
    logic [5:0] code_out;
    logic       lock;
    logic       at_limit;
    logic       sel_err;
    logic       upd;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int base;

    fmc_delay_ctrl #(.CODE_W(6), .CODE_INIT(32), .LOCK_CNT(4)) dut (
        .clk_ext  (clk_ext),
        .rst_n    (rst_n),
        .DIV_M    (DIV_M),
        .Sel      (Sel),
        .code_out (code_out),
        .lock     (lock),
        .at_limit (at_limit),
        .sel_err  (sel_err),
        .upd      (upd)
    );

    always #5 clk_ext = ~clk_ext;

    always @(negedge clk_ext) begin
        if (upd === 1'b1) upd_cnt <= upd_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One decision slot; returns at the negedge after the update edge.
    task automatic do_slot(input logic [1:0] s);
        @(negedge clk_ext);
        DIV_M = 1'b1;
        Sel   = s;
        @(negedge clk_ext);
        DIV_M = 1'b0;
        Sel   = 2'b00;
    endtask

    // Asynchronous reset pulse, checked before any clock edge occurs.
    task automatic pulse_reset(input string tag);
        @(negedge clk_ext);
        #1 rst_n = 1'b0;
        #1 check(tag, int'(code_out), 32);
        @(negedge clk_ext);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk_ext);
        @(negedge clk_ext);
        check("rst_code", int'(code_out), 32);
        check("rst_lock", int'(lock), 0);
        check("rst_at_limit", int'(at_limit), 0);
        check("rst_sel_err", int'(sel_err), 0);
        check("rst_upd", int'(upd), 0);
        rst_n = 1'b1;

`ifdef FMC_SEL_FILTER_EN
        do_slot(2'b01);
        check("flt_s1_code", int'(code_out), 32);
        check("flt_s1_upd", int'(upd), 1);
        do_slot(2'b00);
        check("flt_s2_code", int'(code_out), 32);
        do_slot(2'b01);
        check("flt_s3_code", int'(code_out), 33);
        do_slot(2'b01);
        check("flt_s4_code", int'(code_out), 34);
        do_slot(2'b11);
        check("flt_ill_code", int'(code_out), 35);
        check("flt_ill_err", int'(sel_err), 1);
        pulse_reset("flt_async_rst_code");
        check("flt_rst_err", int'(sel_err), 0);
        do_slot(2'b01);
        check("flt_hist_clr1", int'(code_out), 32);
        do_slot(2'b01);
        check("flt_hist_clr2", int'(code_out), 33);
`else
        base = upd_cnt;
        for (int i = 0; i < 5; i++) begin
            do_slot(2'b01);
            check("inc_upd_pulse", int'(upd), 1);
        end
        @(negedge clk_ext);
        check("inc_upd_low", int'(upd), 0);
        check("inc5_code", int'(code_out), 37);
        check("inc5_upd_count", upd_cnt - base, 5);
        check("inc5_lock", int'(lock), 0);

        pulse_reset("async_rst_code");
        do_slot(2'b01);
        check("alt1_code", int'(code_out), 33);
        check("alt1_lock", int'(lock), 0);
        do_slot(2'b10);
        check("alt2_code", int'(code_out), 32);
        do_slot(2'b01);
        check("alt3_code", int'(code_out), 33);
        check("alt3_lock", int'(lock), 0);
        do_slot(2'b10);
        check("alt4_code", int'(code_out), 32);
        check("alt4_lock", int'(lock), 1);

        do_slot(2'b10);
        check("same1_code", int'(code_out), 31);
        check("same1_lock", int'(lock), 1);
        do_slot(2'b10);
        check("same2_code", int'(code_out), 30);
        check("same2_lock", int'(lock), 0);

        do_slot(2'b11);
        check("ill_code", int'(code_out), 30);
        check("ill_err", int'(sel_err), 1);
        do_slot(2'b00);
        do_slot(2'b01);
        check("ill_sticky", int'(sel_err), 1);
        check("post_ill_code", int'(code_out), 31);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk_ext);
            Sel = 2'b01;
        end
        @(negedge clk_ext);
        Sel = 2'b00;
        check("sel_outside_slot", int'(code_out), 31);

        base = upd_cnt;
        @(negedge clk_ext);
        DIV_M = 1'b1;
        Sel   = 2'b10;
        repeat (10) @(negedge clk_ext);
        DIV_M = 1'b0;
        @(negedge clk_ext);
        check("held_high_upd", upd_cnt - base, 1);
        check("held_high_code", int'(code_out), 30);

        @(negedge clk_ext);
        #1 rst_n = 1'b0;
        #1 check("rst2_err_clr", int'(sel_err), 0);
        check("rst2_code", int'(code_out), 32);
        DIV_M = 1'b1;
        Sel   = 2'b01;
        @(negedge clk_ext);
        rst_n = 1'b1;
        @(negedge clk_ext);
        DIV_M = 1'b0;
        Sel   = 2'b00;
        check("first_cycle_slot_code", int'(code_out), 33);
        check("first_cycle_slot_upd", int'(upd), 1);

        for (int i = 0; i < 30; i++) do_slot(2'b01);
        check("max_code", int'(code_out), 63);
        check("max_at_limit", int'(at_limit), 0);
        do_slot(2'b01);
        check("clip_hi_code", int'(code_out), 63);
        check("clip_hi_at_limit", int'(at_limit), 1);
        check("clip_hi_lock", int'(lock), 0);
        do_slot(2'b00);
        check("hold_clears_limit", int'(at_limit), 0);
        for (int i = 0; i < 63; i++) do_slot(2'b10);
        check("min_code", int'(code_out), 0);
        do_slot(2'b10);
        check("clip_lo_code", int'(code_out), 0);
        check("clip_lo_at_limit", int'(at_limit), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fmc_delay_ctrl.md
# fmc_delay_ctrl

Decision consumer at the far end of the frequency-multiplier control loop. Samples the 2-bit `Sel` correction command once per `DIV_M` period and integrates it into a saturating delay-line control code. Runs a lock detector that reports when the loop is dithering around its target. Sits between the frequency/phase decision logic and the digitally controlled delay line, in the `clk_ext` domain.

## Interface
- `CODE_W`, 6: width of delay code.
- `CODE_INIT`, 32: code loaded at reset; must be < 2^CODE_W.
- `LOCK_CNT`, 4: consecutive lock-qualifying decisions needed to assert `lock`; range 2..15.
- `clk_ext`  in  1  reference clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `DIV_M`  in  1  divided reference, synchronous to `clk_ext`; its rising edge marks a decision slot.
- `Sel`  in  2  correction command: 00 hold, 01 increment, 10 decrement, 11 illegal.
- `code_out`  out  CODE_W  delay-line control code.
- `lock`  out  1  loop locked.
- `at_limit`  out  1  last applied move was clipped at 0 or at 2^CODE_W-1.
- `sel_err`  out  1  sticky flag: `Sel`=11 seen in a decision slot.
- `upd`  out  1  one-cycle pulse for each decision slot.

## Operation
- **Decision slot detection.** `DIV_M` is registered into `div_q`. A slot is the cycle where `DIV_M`=1 and `div_q`=0. `Sel` is sampled in that cycle only.
- **Command handling.** Increment adds 1 to the code; decrement subtracts 1; hold leaves it unchanged. Illegal (11) acts as hold and sets `sel_err`.
- **Saturation.** Increment at max and decrement at 0 leave the code unchanged and set `at_limit`. Any non-clipped decision clears `at_limit`.
- **Lock-qualifying decisions.** A decision qualifies if it is a hold, or a move opposite to the last applied move (a dither reversal). A clipped move and a same-direction move both disqualify it.
- **FSM states:**
  - TRACK (reset state): qualifying decision increments `qcnt`; non-qualifying clears it. When `qcnt` reaches LOCK_CNT, go to LOCKED.
  - LOCKED: `lock`=1 and the code still updates. Two consecutive same-direction applied moves return to TRACK with `qcnt` cleared. A clipped move also returns to TRACK.
- **Last-move register.** Stores none/up/down. Holds do not change it; it is reset to none.
- **Reset values.** `code_out`=CODE_INIT; `lock`, `at_limit`, `sel_err`, `upd`=0; `qcnt`=0; `div_q`=0.

## Timing
- Latency from a slot to the new `code_out` is 1 cycle: values update on the clock edge that ends the slot cycle. `upd`, `lock`, and `at_limit` update on that same edge.
- `DIV_M` held high produces one slot only. `DIV_M` high in the first cycle after reset counts as a slot.
- `Sel` changes outside slots are ignored.
- Reset mid-operation restores all reset values asynchronously. The first slot after release is evaluated normally.
- Minimum slot spacing is 2 cycles (`DIV_M` toggling every cycle); every slot must be handled.

## Configuration
- `FMC_SEL_FILTER_EN`: when defined, raw slot commands pass through a 3-deep majority filter before the code update and lock logic.
  - The filtered command is up or down only if at least 2 of the last 3 slots carried that command; otherwise it is hold.
  - Illegal commands enter the history as hold.
  - History resets to hold. Latency in cycles is unchanged.
- Undefined: raw `Sel` is applied directly.

## Structure
- Shared package `fmc_pkg`: `Sel` encoding constants (SEL_HOLD, SEL_INC, SEL_DEC, SEL_ILL), FSM state typedef (TRACK, LOCKED), last-move typedef (NONE, UP, DOWN).
- One sub-module, `fmc_sel_filter`: the majority filter, instantiated only under `FMC_SEL_FILTER_EN`.

## Test plan
- Reset with CODE_INIT=32, then 5 slots of Sel=01 -> `code_out`=37, `upd` pulses 5 times, `lock`=0.
- From 32, alternating 01/10 for 4 slots (LOCK_CNT=4) -> code toggles 33/32, `lock`=1 after the 4th slot (the first move qualifies via 3 reversals plus prior state: verify `lock` rises exactly on the slot where `qcnt` hits 4).
- In LOCKED, two consecutive Sel=10 slots -> `lock` falls 1 cycle after the second slot, code decremented twice.
- With code at 63 (CODE_W=6), Sel=01 -> code stays 63, `at_limit`=1, `lock`=0. A following Sel=00 -> `at_limit`=0.
- Sel=11 in a slot -> code unchanged, `sel_err`=1 and stays set until `rst_n` is asserted. `DIV_M` held high for 10 cycles -> exactly one `upd`.
- With `FMC_SEL_FILTER_EN`, slot sequence 01,00,01 -> code changes only on the third slot. Reset asserted mid-sequence -> code=32, history cleared.
